// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared Tuse/RES/forward encodings, tag record and helper functions
package hazard_ctrl_pkg;
  localparam int TNEW_W = 2;
  localparam logic [1:0] TUSE_0 = 2'd0, TUSE_1 = 2'd1, TUSE_2 = 2'd2, TUSE_NO = 2'd3;
  localparam logic [2:0] RES_NO = 3'd0, RES_ALU = 3'd1, RES_DM = 3'd2, RES_PC = 3'd3;
  localparam logic [1:0] FW_RF = 2'd0, FW_E = 2'd1, FW_M = 2'd2, FW_W = 2'd3;
  localparam logic [TNEW_W-1:0] TNEW_ALU = 2'd1, TNEW_DM = 2'd2, TNEW_PC = 2'd0;
  typedef struct packed {
    logic [4:0]        a3;
    logic [TNEW_W-1:0] tnew;
    logic [4:0]        rt;
  } tag_t;
  function automatic logic [TNEW_W-1:0] tnew_of(input logic [2:0] res);
    return (res == RES_ALU) ? TNEW_ALU : (res == RES_DM) ? TNEW_DM : (res == RES_PC) ? TNEW_PC : '0;
  endfunction
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction
  function automatic logic hit(input logic [4:0] src, input logic [4:0] a3);
    return (src == a3) && (a3 != 5'd0);
  endfunction
  // Youngest qualifying stage wins; W needs only an address match since its Tnew is always 0.
  function automatic logic [1:0] fwd_sel(input logic [4:0] s, input logic use_e, input tag_t e,
                                         input tag_t m, input logic [4:0] w_a3);
    return (use_e && hit(s, e.a3) && e.tnew == '0) ? FW_E :
           (hit(s, m.a3) && m.tnew == '0) ? FW_M :
           hit(s, w_a3) ? FW_W : FW_RF;
  endfunction
endpackage

// File: rtl/hazard_ctrl_tag_stage.sv
// hazard_tag_stage: one shadow-pipeline tag register with bubble insert and optional Tnew countdown
module hazard_tag_stage
  import hazard_ctrl_pkg::*;
#(
  parameter bit DEC = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_bubble,
  input  tag_t i_tag,
  output tag_t o_tag
);
  tag_t r_tag;
  always_ff @(posedge clk)
    if (reset || i_bubble) r_tag <= '0;
    else r_tag <= '{a3: i_tag.a3, tnew: DEC ? sat_dec(i_tag.tnew) : i_tag.tnew, rt: i_tag.rt};
  assign o_tag = r_tag;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: MIPS 5-stage stall and forwarding control from E/M/W write tags.
// Optional stall_cnt output enabled by HAZARD_STALL_CNT_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Tuse_rs_D,
  input  logic [1:0] Tuse_rt_D,
  input  logic [2:0] RES_D,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] A3_D,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic [1:0] fwd_rt_M
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  tag_t w_d, w_e, w_m, w_w;
  logic [4:0] r_rs_e;
  logic w_stall, w_unused;
  assign w_d = '{a3: (RES_D == RES_NO) ? 5'd0 : A3_D, tnew: tnew_of(RES_D), rt: rt_D};
  hazard_tag_stage #(.DEC(1'b0)) u_e (.clk(clk), .reset(reset), .i_bubble(w_stall), .i_tag(w_d), .o_tag(w_e));
  hazard_tag_stage #(.DEC(1'b1)) u_m (.clk(clk), .reset(reset), .i_bubble(1'b0), .i_tag(w_e), .o_tag(w_m));
  hazard_tag_stage #(.DEC(1'b1)) u_w (.clk(clk), .reset(reset), .i_bubble(1'b0), .i_tag(w_m), .o_tag(w_w));
  always_ff @(posedge clk)
    r_rs_e <= (reset || w_stall) ? 5'd0 : rs_D;
  assign w_unused = ^{w_w.tnew, w_w.rt};
  assign w_stall = !reset && (
    (hit(rs_D, w_e.a3) && Tuse_rs_D < w_e.tnew) || (hit(rs_D, w_m.a3) && Tuse_rs_D < w_m.tnew) ||
    (hit(rt_D, w_e.a3) && Tuse_rt_D < w_e.tnew) || (hit(rt_D, w_m.a3) && Tuse_rt_D < w_m.tnew));
  assign stall    = w_stall;
  assign fwd_rs_D = reset ? FW_RF : fwd_sel(rs_D, 1'b1, w_e, w_m, w_w.a3);
  assign fwd_rt_D = reset ? FW_RF : fwd_sel(rt_D, 1'b1, w_e, w_m, w_w.a3);
  assign fwd_rs_E = reset ? FW_RF : fwd_sel(r_rs_e, 1'b0, w_e, w_m, w_w.a3);
  assign fwd_rt_E = reset ? FW_RF : fwd_sel(w_e.rt, 1'b0, w_e, w_m, w_w.a3);
  assign fwd_rt_M = (!reset && hit(w_m.rt, w_w.a3)) ? FW_W : FW_RF;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk)
    if (reset) r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
  assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus random traffic against an in-flight instruction model
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] Tuse_rs_D, Tuse_rt_D;
  logic [2:0] RES_D;
  logic [4:0] rs_D, rt_D, A3_D;
  logic stall;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  int n_chk = 0, n_pass = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D), .RES_D(RES_D),
    .rs_D(rs_D), .rt_D(rt_D), .A3_D(A3_D), .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // in-flight instructions: index 0 = E, 1 = M, 2 = W; tn is Tnew when it entered E
  typedef struct {logic [4:0] a3, rs, rt; int tn;} ins_t;
  ins_t pipe[3];
  logic [31:0] m_cnt;
  logic m_stall;
  logic [1:0] m_frsd, m_frtd, m_frse, m_frte, m_frtm;

  typedef struct {
    logic rst; logic [1:0] tr, tt; logic [2:0] res; logic [4:0] rs, rt, a3;
    logic es; logic [1:0] ersd, ertd, erse, erte, ertm;
  } vec_t;
  vec_t tbl[$];

  function automatic int rem(int k);
    return pipe[k].tn > k ? pipe[k].tn - k : 0;
  endfunction
  function automatic bit m_hit(logic [4:0] s, int k);
    return s != 5'd0 && s == pipe[k].a3;
  endfunction
  function automatic logic [1:0] m_sel(logic [4:0] s, int first);
    for (int k = first; k < 3; k++) if (m_hit(s, k) && rem(k) == 0) return 2'(k + 1);
    return 2'd0;
  endfunction

  task automatic model_eval();
    m_stall = 1'b0;
    for (int k = 0; k < 2; k++)
      if ((m_hit(rs_D, k) && int'(Tuse_rs_D) < rem(k)) || (m_hit(rt_D, k) && int'(Tuse_rt_D) < rem(k)))
        m_stall = 1'b1;
    m_frsd = m_sel(rs_D, 0);
    m_frtd = m_sel(rt_D, 0);
    m_frse = m_sel(pipe[0].rs, 1);
    m_frte = m_sel(pipe[0].rt, 1);
    m_frtm = m_hit(pipe[1].rt, 2) ? 2'd3 : 2'd0;
    if (reset) {m_stall, m_frsd, m_frtd, m_frse, m_frte, m_frtm} = '0;
  endtask

  task automatic model_tick();
    if (reset) begin
      for (int k = 0; k < 3; k++) pipe[k] = '{a3: 5'd0, rs: 5'd0, rt: 5'd0, tn: 0};
      m_cnt = '0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = m_stall ? '{a3: 5'd0, rs: 5'd0, rt: 5'd0, tn: 0} :
                '{a3: (RES_D == RES_NO) ? 5'd0 : A3_D, rs: rs_D, rt: rt_D,
                  tn: (RES_D == RES_ALU) ? 1 : (RES_D == RES_DM) ? 2 : 0};
      if (m_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic drive(logic r, logic [1:0] tr, logic [1:0] tt, logic [2:0] res,
                       logic [4:0] rs, logic [4:0] rt, logic [4:0] a3);
    @(negedge clk);
    reset = r; Tuse_rs_D = tr; Tuse_rt_D = tt; RES_D = res; rs_D = rs; rt_D = rt; A3_D = a3;
    #1;
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", n, act, exp);
    else n_pass++;
  endtask

  task automatic chk_out(string t, logic es, logic [1:0] a, logic [1:0] b, logic [1:0] c,
                         logic [1:0] d, logic [1:0] e);
    chk({t, " stall"}, 32'(stall), 32'(es));
    chk({t, " fwd_rs_D"}, 32'(fwd_rs_D), 32'(a));
    chk({t, " fwd_rt_D"}, 32'(fwd_rt_D), 32'(b));
    chk({t, " fwd_rs_E"}, 32'(fwd_rs_E), 32'(c));
    chk({t, " fwd_rt_E"}, 32'(fwd_rt_E), 32'(d));
    chk({t, " fwd_rt_M"}, 32'(fwd_rt_M), 32'(e));
  endtask

  task automatic step(string t, logic r, logic [1:0] tr, logic [1:0] tt, logic [2:0] res,
                      logic [4:0] rs, logic [4:0] rt, logic [4:0] a3);
    drive(r, tr, tt, res, rs, rt, a3);
    model_eval();
    chk_out(t, m_stall, m_frsd, m_frtd, m_frse, m_frte, m_frtm);
`ifdef HAZARD_STALL_CNT_EN
    chk({t, " stall_cnt"}, stall_cnt, m_cnt);
`endif
    model_tick();
  endtask

  task automatic row(logic r, logic [1:0] tr, logic [1:0] tt, logic [2:0] res, logic [4:0] rs,
                     logic [4:0] rt, logic [4:0] a3, logic es, logic [1:0] a, logic [1:0] b,
                     logic [1:0] c, logic [1:0] d, logic [1:0] e);
    vec_t v;
    v = '{r, tr, tt, res, rs, rt, a3, es, a, b, c, d, e};
    tbl.push_back(v);
  endtask

  task automatic nop(logic [1:0] c, logic [1:0] e);
    row(0, TUSE_NO, TUSE_NO, RES_NO, 0, 0, 0, 0, 0, 0, c, 0, e);
  endtask

  initial begin
    reset = 1'b1; Tuse_rs_D = TUSE_NO; Tuse_rt_D = TUSE_NO; RES_D = RES_NO;
    rs_D = 0; rt_D = 0; A3_D = 0;
    m_cnt = '0;
    for (int k = 0; k < 3; k++) pipe[k] = '{a3: 5'd0, rs: 5'd0, rt: 5'd0, tn: 0};
    row(1, TUSE_1, TUSE_NO, RES_DM, 29, 8, 8, 0, 0, 0, 0, 0, 0);
    nop(0, 0);
    row(0, TUSE_1, TUSE_NO, RES_DM, 29, 8, 8, 0, 0, 0, 0, 0, 0);
    row(0, TUSE_1, TUSE_1, RES_ALU, 8, 10, 9, 1, 0, 0, 0, 0, 0);
    row(0, TUSE_1, TUSE_1, RES_ALU, 8, 10, 9, 0, 0, 0, 0, 0, 0);
    nop(3, 0); nop(0, 0); nop(0, 0);
    row(0, TUSE_1, TUSE_NO, RES_ALU, 6, 5, 5, 0, 0, 0, 0, 0, 0);
    row(0, TUSE_0, TUSE_0, RES_NO, 5, 7, 0, 1, 0, 0, 0, 0, 0);
    row(0, TUSE_0, TUSE_0, RES_NO, 5, 7, 0, 0, 2, 0, 0, 0, 0);
    nop(3, 0); nop(0, 0);
    row(0, TUSE_NO, TUSE_NO, RES_PC, 0, 0, 31, 0, 0, 0, 0, 0, 0);
    row(0, TUSE_0, TUSE_NO, RES_NO, 31, 0, 0, 0, 1, 0, 0, 0, 0);
    nop(2, 0); nop(0, 0); nop(0, 0);
    row(0, TUSE_1, TUSE_NO, RES_DM, 29, 4, 4, 0, 0, 0, 0, 0, 0);
    row(0, TUSE_1, TUSE_2, RES_NO, 29, 4, 0, 0, 0, 0, 0, 0, 0);
    nop(0, 0); nop(0, 3); nop(0, 0);
    row(0, TUSE_1, TUSE_1, RES_ALU, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    row(0, TUSE_0, TUSE_0, RES_NO, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(0, 0);
    row(0, TUSE_1, TUSE_NO, RES_DM, 29, 8, 8, 0, 0, 0, 0, 0, 0);
    row(1, TUSE_1, TUSE_1, RES_ALU, 8, 10, 9, 0, 0, 0, 0, 0, 0);
    row(0, TUSE_1, TUSE_1, RES_ALU, 8, 10, 9, 0, 0, 0, 0, 0, 0);
    nop(0, 0);
    row(0, TUSE_NO, TUSE_NO, RES_ALU, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    row(0, TUSE_NO, TUSE_NO, RES_PC, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    row(0, TUSE_1, TUSE_NO, RES_NO, 3, 0, 0, 0, 1, 0, 0, 0, 0);
    nop(2, 0); nop(0, 0);
    row(0, TUSE_NO, TUSE_NO, RES_DM, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    row(0, TUSE_NO, TUSE_NO, RES_PC, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    row(0, TUSE_0, TUSE_NO, RES_NO, 3, 0, 0, 1, 1, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].tr, tbl[i].tt, tbl[i].res, tbl[i].rs, tbl[i].rt, tbl[i].a3);
      model_eval();
      chk_out($sformatf("row%0d", i), tbl[i].es, tbl[i].ersd, tbl[i].ertd, tbl[i].erse,
              tbl[i].erte, tbl[i].ertm);
      model_tick();
    end
`ifdef HAZARD_STALL_CNT_EN
    step("cnt rst", 1, TUSE_NO, TUSE_NO, RES_NO, 0, 0, 0);
    step("cnt nop", 0, TUSE_NO, TUSE_NO, RES_NO, 0, 0, 0);
    chk("stall_cnt after reset", stall_cnt, 32'd0);
    for (int n = 0; n < 2; n++) begin
      step("cnt lw", 0, TUSE_1, TUSE_NO, RES_DM, 29, 8, 8);
      step("cnt use", 0, TUSE_1, TUSE_1, RES_ALU, 8, 10, 9);
      step("cnt use2", 0, TUSE_1, TUSE_1, RES_ALU, 8, 10, 9);
      step("cnt nop", 0, TUSE_NO, TUSE_NO, RES_NO, 0, 0, 0);
      step("cnt nop", 0, TUSE_NO, TUSE_NO, RES_NO, 0, 0, 0);
    end
    chk("stall_cnt two stalls", stall_cnt, 32'd2);
`endif
    for (int n = 0; n < 3000; n++)
      step($sformatf("rnd%0d", n), $urandom_range(49) == 0, 2'($urandom_range(3)), 2'($urandom_range(3)),
           3'($urandom_range(3)), 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Downstream consumer of the D-stage Tuse/RES decode in the 5-stage MIPS pipeline.
- Keeps a shadow pipeline of register-write tags (dest reg A3, Tnew) for the E, M and W stages.
- Compares those tags against the D-stage instruction's sources and Tuse values.
- Produces the global stall (freeze PC and IF/ID, bubble into ID/EX) and all forwarding-mux selects for D, E and M.

Parameters:
- TNEW_W, 2, width of the Tnew field held per stage (max Tnew = 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Tuse_rs_D  in  2  D-stage rs use time: 0, 1, 2; 3 = no use
- Tuse_rt_D  in  2  D-stage rt use time, same encoding
- RES_D  in  3  D-stage result source: RES_NO=0, RES_ALU=1, RES_DM=2, RES_PC=3
- rs_D  in  5  D-stage rs field
- rt_D  in  5  D-stage rt field
- A3_D  in  5  D-stage write-destination register, already muxed rd/rt/31
- stall  out  1  hold PC and IF/ID, clear ID/EX
- fwd_rs_D  out  2  select for D-stage rs operand: 0 RF, 1 E, 2 M, 3 W
- fwd_rt_D  out  2  select for D-stage rt operand, same encoding
- fwd_rs_E  out  2  select for E-stage rs operand: 0 pipeline reg, 2 M, 3 W
- fwd_rt_E  out  2  select for E-stage rt operand, same encoding
- fwd_rt_M  out  2  select for M-stage rt (store data): 0 pipeline reg, 3 W

Behaviour:
- D-tag (combinational):
  - A3 = (RES_D==RES_NO) ? 0 : A3_D.
  - Tnew_E_in: ALU→1, DM→2, PC→0, NO→0.
- Tag registers, updated every posedge clk:
  - E ← stall ? bubble (A3=0, Tnew=0, rs=0, rt=0) : {D-tag, rs_D, rt_D}.
  - M ← {E.A3, sat_dec(E.Tnew), E.rt}; sat_dec(0)=0.
  - W ← {M.A3}. Tnew at W is always 0.
- Register 0 never matches. Any comparison with A3==0 is false.
- stall = OR over src∈{rs,rt} and stage∈{E,M} of (src_D==stage.A3 && src_D!=0 && Tuse_src_D < stage.Tnew).
  - Tuse=3 never stalls.
  - stall is combinational in the same cycle as D decode.
- Forward select priority is youngest first: E > M > W.
  - A stage qualifies only when its A3 matches, A3≠0 and its Tnew==0.
  - fwd_*_D: E(1) if E qualifies; else M(2) if M qualifies; else W(3) if W.A3 matches; else 0.
  - fwd_*_E: M(2) if M qualifies, else W(3), else 0.
  - fwd_rt_M: W(3) if W.A3==M.rt≠0, else 0.
- Forward selects are valid even when stall=1. The stalled D instruction simply re-evaluates next cycle.
- Reset:
  - On posedge with reset=1, all tag registers clear to 0.
  - While reset=1, stall=0 and all fwd outputs = 0, regardless of inputs.
  - Reset mid-stall: the bubble and the stall are both dropped; the next cycle after deassert evaluates from clean tags.
- Latency: a D instruction's tag is visible in E one cycle after it leaves D (only when not stalled), then in M one cycle later, then in W.
- Simultaneous hazards (E and M both match):
  - Stall if either stage requires it.
  - Forwarding uses E first.
- Forward select is a pure function of current tags plus D inputs. There is no extra state.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0]: number of cycles with stall=1 since reset, saturating at 32'hFFFF_FFFF.
  - Cleared by reset.
  - Counts in the cycle where stall is asserted, visible the following cycle.
- Undefined: port and counter absent. All other behaviour identical.

Decomposition:
- Shared defines:
  - Tuse_0/1/2/no.
  - RES_NO/ALU/DM/PC.
  - FW_RF=0, FW_E=1, FW_M=2, FW_W=3.
  - Tnew-per-RES table values.
- One natural sub-module, hazard_tag_stage: a single tag register (A3, Tnew, rt) with bubble input and saturating Tnew decrement. Instantiated for E, M and W.

Test Plan:
- lw $8 (RES_DM, A3=8) then addu using rs=8 (Tuse_rs=1):
  - stall=1 for exactly 1 cycle, then fwd_rs_E=3 (W) when addu reaches E.
- ori $5 (ALU) then beq rs=5 (Tuse_rs=0):
  - cycle 1: stall=1 (E.Tnew=1).
  - cycle 2: stall=0, fwd_rs_D=2 (M).
- jal (RES_PC, A3=31) then jr $31 (Tuse_rs=0):
  - stall=0, fwd_rs_D=1 (E).
- lw $4 then sw rt=4 (Tuse_rt=2):
  - stall=0, fwd_rt_M=3 when sw in M.
- addu $0 then beq rs=0: no stall, all fwd=0.
- reset asserted during an lw/addu stall: next cycle stall=0 and fwd=0. With HAZARD_STALL_CNT_EN, stall_cnt=0 after reset and =2 after two isolated lw-use stalls.
